// File: rtl/if_pkg.sv
// Shared types and constants for the MIPS instruction-fetch stage.
package if_pkg;

  typedef enum logic [0:0] {
    S_FETCH = 1'b0,
    S_HOLD  = 1'b1
  } if_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] PC_STEP   = 32'd4;

  // Branch targets are always word aligned.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_perf_cnt.sv
// Three free-running, wrapping event counters for the fetch stage.
// Instantiated by if_stage only when IF_FETCH_CNT_EN is defined.
module if_perf_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_fetch_inc,
  input  logic             i_stall_inc,
  input  logic             i_kill_inc,
  output logic [CNT_W-1:0] o_fetch_cnt,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_kill_cnt
);

  logic [CNT_W-1:0] r_fetch_cnt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_kill_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_cnt <= '0;
      r_stall_cnt <= '0;
      r_kill_cnt  <= '0;
    end else begin
      if (i_fetch_inc) r_fetch_cnt <= r_fetch_cnt + 1'b1;
      if (i_stall_inc) r_stall_cnt <= r_stall_cnt + 1'b1;
      if (i_kill_inc)  r_kill_cnt  <= r_kill_cnt + 1'b1;
    end
  end

  assign o_fetch_cnt = r_fetch_cnt;
  assign o_stall_cnt = r_stall_cnt;
  assign o_kill_cnt  = r_kill_cnt;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, req/ack fetch FSM, IF/ID register.
// Performance counters are built only when IF_FETCH_CNT_EN is defined.
module if_stage
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             freeze,
  input  logic             Br_taken,
  input  logic [31:0]      Br_addr,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      Instruction,
  output logic [31:0]      PC,
  output logic             valid,
  output logic [CNT_W-1:0] fetch_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] kill_cnt
);

  if_state_e   r_state;
  logic [31:0] r_pc;
  logic        r_kill;
  logic [31:0] r_redirect;
  logic [31:0] r_hold_instr;
  logic [31:0] r_hold_pc;
  logic [31:0] r_instr;
  logic [31:0] r_if_pc;
  logic        r_valid;

  logic        w_ack;
  logic [31:0] w_br_target;
  logic [31:0] w_pc_next;
  logic        w_load_fetch;
  logic        w_load_hold;
  logic        w_unused_br_lsb;

  // Acks outside an active request (e.g. left over from before reset) are ignored.
  assign imem_req        = !rst && (r_state == S_FETCH);
  assign imem_addr       = r_pc;
  assign w_ack           = imem_ack && imem_req;
  assign w_br_target     = word_align(Br_addr);
  assign w_unused_br_lsb = ^Br_addr[1:0];
  assign w_pc_next       = r_pc + PC_STEP;

  assign w_load_fetch = (r_state == S_FETCH) && w_ack && !Br_taken && !r_kill && !freeze;
  assign w_load_hold  = (r_state == S_HOLD) && !Br_taken && !freeze;

  // NOTE: every register here, including the hold buffer, is reset so that a
  // mid-transaction reset leaves no stale instruction that could leak into IF/ID.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_FETCH;
      r_pc         <= RESET_PC;
      r_kill       <= 1'b0;
      r_redirect   <= '0;
      r_hold_instr <= NOP_INSTR;
      r_hold_pc    <= '0;
      r_instr      <= NOP_INSTR;
      r_if_pc      <= '0;
      r_valid      <= 1'b0;
    end else begin
      // IF/ID register: flush > freeze > new instruction > bubble.
      if (Br_taken) begin
        r_instr <= NOP_INSTR;
        r_valid <= 1'b0;
      end else if (freeze) begin
        r_instr <= r_instr;
      end else if (w_load_fetch) begin
        r_instr <= imem_rdata;
        r_if_pc <= w_pc_next;
        r_valid <= 1'b1;
      end else if (w_load_hold) begin
        r_instr <= r_hold_instr;
        r_if_pc <= r_hold_pc;
        r_valid <= 1'b1;
      end else begin
        r_instr <= NOP_INSTR;
        r_valid <= 1'b0;
      end

      unique case (r_state)
        S_FETCH: begin
          if (w_ack) begin
            if (Br_taken || r_kill) begin
              // Wrong-path response: drop it and restart at the target.
              r_pc   <= Br_taken ? w_br_target : r_redirect;
              r_kill <= 1'b0;
            end else begin
              r_pc <= w_pc_next;
              if (freeze) begin
                r_hold_instr <= imem_rdata;
                r_hold_pc    <= w_pc_next;
                r_state      <= S_HOLD;
              end
            end
          end else if (Br_taken) begin
            // Address must stay stable until ack, so remember the target.
            r_kill     <= 1'b1;
            r_redirect <= w_br_target;
          end
        end
        S_HOLD: begin
          if (Br_taken) begin
            r_pc    <= w_br_target;
            r_state <= S_FETCH;
          end else if (!freeze) begin
            r_state <= S_FETCH;
          end
        end
        default: r_state <= S_FETCH;
      endcase
    end
  end

  assign Instruction = r_instr;
  assign PC          = r_if_pc;
  assign valid       = r_valid;

`ifdef IF_FETCH_CNT_EN
  logic w_fetch_inc;
  logic w_stall_inc;
  logic w_kill_inc;

  assign w_fetch_inc = w_load_fetch || w_load_hold;
  assign w_stall_inc = freeze && r_valid;
  assign w_kill_inc  = (w_ack && (Br_taken || r_kill)) ||
                       ((r_state == S_HOLD) && Br_taken);

  if_perf_cnt #(
    .CNT_W (CNT_W)
  ) u_perf_cnt (
    .clk         (clk),
    .rst         (rst),
    .i_fetch_inc (w_fetch_inc),
    .i_stall_inc (w_stall_inc),
    .i_kill_inc  (w_kill_inc),
    .o_fetch_cnt (fetch_cnt),
    .o_stall_cnt (stall_cnt),
    .o_kill_cnt  (kill_cnt)
  );
`else
  assign fetch_cnt = '0;
  assign stall_cnt = '0;
  assign kill_cnt  = '0;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed self-checking bench for if_stage with a wait-state memory model
// whose returned instruction is the fetch address XOR a fixed key.
module tb_if_stage;

  localparam logic [31:0] KEY = 32'hDEAD_0000;

  logic        clk;
  logic        rst;
  logic        freeze;
  logic        Br_taken;
  logic [31:0] Br_addr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] Instruction;
  logic [31:0] PC;
  logic        valid;
  logic [31:0] fetch_cnt;
  logic [31:0] stall_cnt;
  logic [31:0] kill_cnt;

  int n_checks = 0;
  int n_errors = 0;
  int waits    = 0;
  int wait_cnt;

  if_stage #(
    .RESET_PC (32'h0000_0000),
    .CNT_W    (32)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .freeze      (freeze),
    .Br_taken    (Br_taken),
    .Br_addr     (Br_addr),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .Instruction (Instruction),
    .PC          (PC),
    .valid       (valid),
    .fetch_cnt   (fetch_cnt),
    .stall_cnt   (stall_cnt),
    .kill_cnt    (kill_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: ack after `waits` wait states, combinationally when waits == 0.
  assign imem_ack   = imem_req && (wait_cnt >= waits);
  assign imem_rdata = imem_addr ^ KEY;

  always @(posedge clk or posedge rst) begin
    if (rst) wait_cnt <= 0;
    else if (!imem_req || imem_ack) wait_cnt <= 0;
    else wait_cnt <= wait_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

`ifdef IF_FETCH_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  function automatic logic [31:0] cnt_exp(input logic [31:0] v);
    return CNT_ON ? v : 32'h0;
  endfunction

  initial begin
    rst      = 1'b0;
    freeze   = 1'b0;
    Br_taken = 1'b0;
    Br_addr  = 32'h0;
    #1 rst = 1'b1;
    tick();
    tick();
    check("rst_valid", {31'b0, valid}, 32'h0);
    check("rst_instr", Instruction, 32'h0);
    check("rst_pc", PC, 32'h0);
    check("rst_req", {31'b0, imem_req}, 32'h0);
    check("rst_fetch_cnt", fetch_cnt, 32'h0);

    // Zero-wait memory: one instruction per cycle.
    rst = 1'b0;
    #1;
    check("rel_req", {31'b0, imem_req}, 32'h1);
    check("rel_addr", imem_addr, 32'h0);
    tick();
    check("zw_pc0", PC, 32'h4);
    check("zw_valid0", {31'b0, valid}, 32'h1);
    check("zw_instr0", Instruction, 32'h0 ^ KEY);
    tick();
    check("zw_pc1", PC, 32'h8);
    tick();
    check("zw_pc2", PC, 32'hC);
    check("zw_instr2", Instruction, 32'h8 ^ KEY);

    // Two wait states: one instruction every third cycle.
    waits = 2;
    tick();
    check("lat_bubble0", {31'b0, valid}, 32'h0);
    check("lat_addr0", imem_addr, 32'hC);
    tick();
    check("lat_bubble1", {31'b0, valid}, 32'h0);
    check("lat_addr1", imem_addr, 32'hC);
    tick();
    check("lat_valid", {31'b0, valid}, 32'h1);
    check("lat_pc", PC, 32'h10);
    check("lat_instr", Instruction, 32'hC ^ KEY);

    // Freeze for four cycles while the fetch of 0x10 completes.
    freeze = 1'b1;
    tick();
    tick();
    check("frz_instr_held", Instruction, 32'hC ^ KEY);
    tick();
    check("frz_hold_req", {31'b0, imem_req}, 32'h0);
    check("frz_hold_instr", Instruction, 32'hC ^ KEY);
    tick();
    check("frz_hold_valid", {31'b0, valid}, 32'h1);
    freeze = 1'b0;
    tick();
    check("unfrz_instr", Instruction, 32'h10 ^ KEY);
    check("unfrz_pc", PC, 32'h14);
    check("unfrz_req", {31'b0, imem_req}, 32'h1);
    check("unfrz_addr", imem_addr, 32'h14);
    check("stall_cnt4", stall_cnt, cnt_exp(32'd4));

    // Branch during a pending fetch; target has non-zero low bits.
    Br_taken = 1'b1;
    Br_addr  = 32'h41;
    tick();
    Br_taken = 1'b0;
    check("br_nop_valid", {31'b0, valid}, 32'h0);
    check("br_nop_instr", Instruction, 32'h0);
    check("br_addr_stable", imem_addr, 32'h14);
    tick();
    tick();
    check("br_target_addr", imem_addr, 32'h40);
    check("br_kill_valid", {31'b0, valid}, 32'h0);
    check("kill_cnt1", kill_cnt, cnt_exp(32'd1));
    waits = 0;
    tick();
    check("br_target_pc", PC, 32'h44);
    check("br_target_instr", Instruction, 32'h40 ^ KEY);

    // Branch coinciding with a zero-wait ack.
    Br_taken = 1'b1;
    Br_addr  = 32'h80;
    tick();
    Br_taken = 1'b0;
    check("brack_valid", {31'b0, valid}, 32'h0);
    check("brack_addr", imem_addr, 32'h80);
    tick();
    check("brack_pc", PC, 32'h84);
    check("brack_instr", Instruction, 32'h80 ^ KEY);

    // Enter S_HOLD, then flush and freeze together.
    freeze = 1'b1;
    tick();
    check("hold_req", {31'b0, imem_req}, 32'h0);
    check("hold_instr", Instruction, 32'h80 ^ KEY);
    Br_taken = 1'b1;
    Br_addr  = 32'h100;
    tick();
    Br_taken = 1'b0;
    freeze   = 1'b0;
    check("holdbr_valid", {31'b0, valid}, 32'h0);
    check("holdbr_instr", Instruction, 32'h0);
    check("holdbr_req", {31'b0, imem_req}, 32'h1);
    check("holdbr_addr", imem_addr, 32'h100);
    check("kill_cnt3", kill_cnt, cnt_exp(32'd3));
    tick();
    check("holdbr_pc", PC, 32'h104);
    check("holdbr_tinstr", Instruction, 32'h100 ^ KEY);

    // PC wraparound at the top of the address space.
    Br_taken = 1'b1;
    Br_addr  = 32'hFFFF_FFFC;
    tick();
    Br_taken = 1'b0;
    check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    tick();
    check("wrap_pc", PC, 32'h0);
    check("wrap_instr", Instruction, 32'hFFFF_FFFC ^ KEY);
    check("wrap_next_addr", imem_addr, 32'h0);
    check("fetch_cnt9", fetch_cnt, cnt_exp(32'd9));
    check("stall_cnt6", stall_cnt, cnt_exp(32'd6));
    check("kill_cnt4", kill_cnt, cnt_exp(32'd4));

    // Asynchronous reset in the middle of a pending fetch.
    waits = 2;
    tick();
    #1 rst = 1'b1;
    #1;
    check("arst_valid", {31'b0, valid}, 32'h0);
    check("arst_instr", Instruction, 32'h0);
    check("arst_pc", PC, 32'h0);
    check("arst_req", {31'b0, imem_req}, 32'h0);
    check("arst_kill_cnt", kill_cnt, 32'h0);
    tick();
    rst   = 1'b0;
    waits = 0;
    #1;
    check("arst_rel_addr", imem_addr, 32'h0);
    tick();
    check("arst_rel_pc", PC, 32'h4);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
